// File: rtl/gps_emulator_ctrl.sv
// Run-time controller for the multi-satellite GPS emulator: shadow/active
// configuration with epoch-aligned commits, Doppler ramping and start/stop sequencing.
module gps_emulator_ctrl #(
   parameter int Nsat         = 4,
   parameter int EPOCH_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [7:0]            cfg_sat,
   input  logic [2:0]            cfg_field,
   input  logic [31:0]           cfg_data,
   input  logic                  commit,
   output logic                  cfg_err,
   output logic                  enable,
   output logic [Nsat-1:0][31:0] freq,
   output logic [Nsat-1:0][15:0] gain,
   output logic [Nsat-1:0][5:0]  ca_sel,
   output logic [15:0]           noise_gain,
   output logic                  epoch,
   output logic [1:0]            state
);

   localparam int CW = (EPOCH_CYCLES > 2) ? $clog2(EPOCH_CYCLES) : 1;
   localparam logic [CW-1:0] TC_VAL = CW'(EPOCH_CYCLES - 1);

   localparam logic [2:0] F_FREQ  = 3'd0;
   localparam logic [2:0] F_GAIN  = 3'd1;
   localparam logic [2:0] F_CA    = 3'd2;
   localparam logic [2:0] F_RATE  = 3'd3;
   localparam logic [2:0] F_NOISE = 3'd4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          pending_reg, pending_next;
   logic          err_reg;
   logic          tc, drop, wr_ok, load_act, step_rate;
   logic [15:0]   sh_noise_reg, act_noise_reg;

   assign cfg_ready  = !pending_reg;
   assign tc         = (state_reg != IDLE) && (cnt_reg == TC_VAL);
   assign drop       = (cfg_field > F_NOISE)
                    || ((cfg_field != F_NOISE) && (cfg_sat >= 8'(Nsat)))
                    || ((cfg_field == F_CA) && (cfg_data[5:0] > 6'd35));
   assign wr_ok      = cfg_valid && cfg_ready && !drop;
   assign enable     = (state_reg != IDLE);
   assign epoch      = tc;
   assign state      = state_reg;
   assign cfg_err    = err_reg;
   assign noise_gain = act_noise_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         pending_reg <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         pending_reg <= pending_next;
         err_reg     <= cfg_valid && cfg_ready && drop;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      pending_next = pending_reg;
      load_act     = 1'b0;
      step_rate    = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (start) begin
               load_act   = 1'b1;
               state_next = RUN;
            end else if (pending_reg) begin
               load_act = 1'b1;
            end
         end
         RUN, STOPPING: begin
            cnt_next = tc ? '0 : cnt_reg + 1'b1;
            // A commit at the boundary replaces the rate step for that epoch.
            if (tc) begin
               load_act  = pending_reg;
               step_rate = !pending_reg;
            end
            if (state_reg == RUN && stop)
               state_next = STOPPING;
            if (state_reg == STOPPING && tc)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (pending_reg) begin
         if (load_act)
            pending_next = 1'b0;
      end else if (commit) begin
         pending_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_noise_reg  <= '0;
         act_noise_reg <= '0;
      end else begin
         if (wr_ok && cfg_field == F_NOISE)
            sh_noise_reg <= cfg_data[15:0];
         if (load_act)
            act_noise_reg <= sh_noise_reg;
      end
   end

   // Per-satellite shadow and active register sets.
   for (genvar gi = 0; gi < Nsat; gi++) begin : g_sat
      logic        sel;
      logic [31:0] sh_freq_reg, act_freq_reg;
      logic [31:0] sh_rate_reg, act_rate_reg;
      logic [15:0] sh_gain_reg, act_gain_reg;
      logic [5:0]  sh_ca_reg, act_ca_reg;

      assign sel = wr_ok && (cfg_sat == 8'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sh_freq_reg  <= '0;
            act_freq_reg <= '0;
            sh_rate_reg  <= '0;
            act_rate_reg <= '0;
            sh_gain_reg  <= '0;
            act_gain_reg <= '0;
            sh_ca_reg    <= 6'(gi);
            act_ca_reg   <= 6'(gi);
         end else begin
            if (sel && cfg_field == F_FREQ) sh_freq_reg <= cfg_data;
            if (sel && cfg_field == F_GAIN) sh_gain_reg <= cfg_data[15:0];
            if (sel && cfg_field == F_CA)   sh_ca_reg   <= cfg_data[5:0];
            if (sel && cfg_field == F_RATE) sh_rate_reg <= cfg_data;
            if (load_act) begin
               act_freq_reg <= sh_freq_reg;
               act_rate_reg <= sh_rate_reg;
               act_gain_reg <= sh_gain_reg;
               act_ca_reg   <= sh_ca_reg;
            end else if (step_rate) begin
               // Two's-complement rate; modular wrap is intended.
               act_freq_reg <= act_freq_reg + act_rate_reg;
            end
         end
      end

      assign freq[gi]   = act_freq_reg;
      assign gain[gi]   = act_gain_reg;
      assign ca_sel[gi] = act_ca_reg;
   end

endmodule

// File: tb/tb_gps_emulator_ctrl.sv
// Self-checking bench for gps_emulator_ctrl: directed scenarios plus randomized
// traffic against an epoch-age based reference model.
module tb_gps_emulator_ctrl;
   localparam int NSAT = 4;
   localparam int EP   = 10;

   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 1'b0, stop = 1'b0, cfg_valid = 1'b0, commit = 1'b0;
   logic [7:0]  cfg_sat = '0;
   logic [2:0]  cfg_field = '0;
   logic [31:0] cfg_data = '0;
   logic cfg_ready, cfg_err, enable, epoch;
   logic [NSAT-1:0][31:0] freq;
   logic [NSAT-1:0][15:0] gain;
   logic [NSAT-1:0][5:0]  ca_sel;
   logic [15:0] noise_gain;
   logic [1:0]  state;

   int total = 0;
   int bad = 0;

   // Reference model: shadow/active sets, commit flag, mode and cycles since start.
   logic [31:0] m_sh_freq[NSAT], m_act_freq[NSAT], m_sh_rate[NSAT], m_act_rate[NSAT];
   logic [15:0] m_sh_gain[NSAT], m_act_gain[NSAT];
   logic [5:0]  m_sh_ca[NSAT], m_act_ca[NSAT];
   logic [15:0] m_sh_noise, m_act_noise;
   bit m_pending, m_err;
   int m_mode, m_age;

   always #5 clk = ~clk;

   gps_emulator_ctrl #(.Nsat(NSAT), .EPOCH_CYCLES(EP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sat(cfg_sat),
      .cfg_field(cfg_field), .cfg_data(cfg_data), .commit(commit),
      .cfg_err(cfg_err), .enable(enable), .freq(freq), .gain(gain),
      .ca_sel(ca_sel), .noise_gain(noise_gain), .epoch(epoch), .state(state)
   );

   function automatic void model_reset();
      for (int i = 0; i < NSAT; i++) begin
         m_sh_freq[i] = '0; m_act_freq[i] = '0;
         m_sh_rate[i] = '0; m_act_rate[i] = '0;
         m_sh_gain[i] = '0; m_act_gain[i] = '0;
         m_sh_ca[i] = 6'(i); m_act_ca[i] = 6'(i);
      end
      m_sh_noise = '0; m_act_noise = '0;
      m_pending = 1'b0; m_err = 1'b0;
      m_mode = 0; m_age = 0;
   endfunction

   function automatic bit model_epoch();
      return (m_mode != 0) && ((m_age % EP) == EP - 1);
   endfunction

   function automatic void model_edge();
      bit tc, acc, drop, load, stepr;
      tc    = model_epoch();
      acc   = cfg_valid && !m_pending;
      drop  = (cfg_field > 4) || (cfg_field != 4 && cfg_sat >= NSAT)
           || (cfg_field == 2 && cfg_data[5:0] > 35);
      load  = 1'b0;
      stepr = 1'b0;
      if (m_mode == 0) load = start || m_pending;
      else if (tc) begin load = m_pending; stepr = !m_pending; end
      if (load) begin
         for (int i = 0; i < NSAT; i++) begin
            m_act_freq[i] = m_sh_freq[i]; m_act_rate[i] = m_sh_rate[i];
            m_act_gain[i] = m_sh_gain[i]; m_act_ca[i] = m_sh_ca[i];
         end
         m_act_noise = m_sh_noise;
      end else if (stepr) begin
         for (int i = 0; i < NSAT; i++) m_act_freq[i] = m_act_freq[i] + m_act_rate[i];
      end
      m_err = acc && drop;
      if (acc && !drop) begin
         case (cfg_field)
            3'd0: m_sh_freq[cfg_sat] = cfg_data;
            3'd1: m_sh_gain[cfg_sat] = cfg_data[15:0];
            3'd2: m_sh_ca[cfg_sat]   = cfg_data[5:0];
            3'd3: m_sh_rate[cfg_sat] = cfg_data;
            default: m_sh_noise      = cfg_data[15:0];
         endcase
      end
      if (m_pending) m_pending = !load;
      else           m_pending = commit;
      case (m_mode)
         0: if (start) begin m_mode = 1; m_age = 0; end
         1: begin if (stop) m_mode = 2; m_age++; end
         default: begin
            if (tc) begin m_mode = 0; m_age = 0; end
            else m_age++;
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      start = 0; stop = 0; cfg_valid = 0; commit = 0;
      cfg_sat = '0; cfg_field = '0; cfg_data = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wr(input logic [7:0] s, input logic [2:0] f, input logic [31:0] d);
      cfg_valid = 1; cfg_sat = s; cfg_field = f; cfg_data = d;
      $display("txn write sat=%0d field=%0d data=0x%08h ready=%0b", s, f, d, cfg_ready);
      tick();
      cfg_valid = 0;
   endtask

   task automatic wait_epoch(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3 * EP; i++) begin
         if (epoch) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      logic [NSAT-1:0][5:0] exp_ca;
      exp_ca = {6'd3, 6'd2, 6'd1, 6'd0};
      do_reset();
      total++; if (enable !== 1'b0) begin bad++; $display("FAIL reset_enable got=%0b want=0", enable); end
      total++; if (ca_sel !== exp_ca) begin bad++; $display("FAIL reset_ca_sel got=%h want=%h", ca_sel, exp_ca); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%0b want=1", cfg_ready); end
      total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
      total++; if (epoch !== 1'b0 || cfg_err !== 1'b0) begin bad++; $display("FAIL reset_pulses got epoch=%0b err=%0b want 0/0", epoch, cfg_err); end
      wr(8'd1, 3'd0, 32'h1000);
      commit = 1; tick(); commit = 0;
      $display("txn commit idle");
      total++; if (freq[1] !== 32'h0) begin bad++; $display("FAIL idle_commit_early got=0x%08h want=0x00000000", freq[1]); end
      tick();
      total++; if (freq[1] !== 32'h1000) begin bad++; $display("FAIL idle_commit_freq got=0x%08h want=0x00001000", freq[1]); end
   endtask

   task automatic test_commit_run();
      int low;
      bit last_ep, ok;
      logic [15:0] g_at_epoch;
      do_reset();
      start = 1; tick(); start = 0;
      repeat (3) tick();
      cfg_valid = 1; cfg_sat = 8'd0; cfg_field = 3'd1; cfg_data = 32'h4000; commit = 1;
      $display("txn write+commit gain0=0x4000 running");
      tick();
      commit = 0;
      cfg_sat = 8'd1; cfg_data = 32'h22;
      low = 0; last_ep = 0; g_at_epoch = 16'hFFFF;
      for (int i = 0; i < 3 * EP && !cfg_ready; i++) begin
         low++;
         last_ep = epoch;
         if (epoch) g_at_epoch = gain[0];
         tick();
      end
      total++; if (low !== 6) begin bad++; $display("FAIL ready_low_cycles got=%0d want=6", low); end
      total++; if (last_ep !== 1'b1) begin bad++; $display("FAIL ready_until_epoch got=%0b want=1", last_ep); end
      total++; if (g_at_epoch !== 16'h0) begin bad++; $display("FAIL gain_before_edge got=0x%04h want=0x0000", g_at_epoch); end
      total++; if (gain[0] !== 16'h4000) begin bad++; $display("FAIL gain_after_edge got=0x%04h want=0x4000", gain[0]); end
      tick();
      cfg_valid = 0;
      commit = 1; tick(); commit = 0;
      wait_epoch(ok);
      total++; if (!ok) begin bad++; $display("FAIL stalled_wait got=timeout want=epoch"); end
      tick();
      total++; if (gain[1] !== 16'h22) begin bad++; $display("FAIL stalled_write got=0x%04h want=0x0022", gain[1]); end
   endtask

   task automatic test_rate();
      bit ok;
      do_reset();
      wr(8'd2, 3'd0, 32'd3);
      wr(8'd2, 3'd3, 32'hFFFF_FFFB);
      commit = 1; tick(); commit = 0; tick();
      start = 1; tick(); start = 0;
      total++; if (freq[2] !== 32'd3) begin bad++; $display("FAIL rate_start got=0x%08h want=0x00000003", freq[2]); end
      wait_epoch(ok);
      total++; if (!ok || freq[2] !== 32'd3) begin bad++; $display("FAIL rate_mid_epoch got=0x%08h ok=%0b want=0x00000003", freq[2], ok); end
      tick();
      total++; if (freq[2] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rate_epoch1 got=0x%08h want=0xfffffffe", freq[2]); end
      wait_epoch(ok);
      tick();
      total++; if (!ok || freq[2] !== 32'hFFFF_FFF9) begin bad++; $display("FAIL rate_epoch2 got=0x%08h ok=%0b want=0xfffffff9", freq[2], ok); end
   endtask

   task automatic test_invalid();
      logic [7:0]  sats[3]   = '{8'd4, 8'd0, 8'd0};
      logic [2:0]  fields[3] = '{3'd0, 3'd5, 3'd2};
      logic [31:0] datas[3]  = '{32'h123, 32'h77, 32'd36};
      logic [NSAT-1:0][5:0] exp_ca;
      exp_ca = {6'd3, 6'd2, 6'd1, 6'd0};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL invalid_ready[%0d] got=%0b want=1", k, cfg_ready); end
         wr(sats[k], fields[k], datas[k]);
         total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL invalid_err[%0d] got=%0b want=1", k, cfg_err); end
         tick();
         total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL invalid_err_len[%0d] got=%0b want=0", k, cfg_err); end
      end
      commit = 1; tick(); commit = 0; tick();
      total++; if (ca_sel !== exp_ca) begin bad++; $display("FAIL invalid_ca got=%h want=%h", ca_sel, exp_ca); end
      total++; if (freq !== '0 || noise_gain !== 16'h0) begin bad++; $display("FAIL invalid_freq got=%h noise=%h want=0", freq, noise_gain); end
   endtask

   task automatic test_stop();
      bit en_ok, ok;
      do_reset();
      start = 1; tick(); start = 0;
      repeat (2) tick();
      stop = 1; tick(); stop = 0;
      $display("txn stop at counter 2");
      total++; if (state !== 2'd2 || enable !== 1'b1) begin bad++; $display("FAIL stop_enter got state=%0d en=%0b want 2/1", state, enable); end
      start = 1; tick(); start = 0;
      total++; if (state !== 2'd2) begin bad++; $display("FAIL stop_ignore_start got=%0d want=2", state); end
      en_ok = 1'b1; ok = 1'b0;
      for (int i = 0; i < 3 * EP; i++) begin
         if (enable !== 1'b1) en_ok = 1'b0;
         if (epoch) begin ok = 1'b1; break; end
         tick();
      end
      total++; if (!ok || !en_ok) begin bad++; $display("FAIL stop_hold got epoch=%0b en_held=%0b want 1/1", ok, en_ok); end
      tick();
      total++; if (enable !== 1'b0 || state !== 2'd0) begin bad++; $display("FAIL stop_done got en=%0b state=%0d want 0/0", enable, state); end
      tick();
      total++; if (state !== 2'd0) begin bad++; $display("FAIL stop_stays_idle got=%0d want=0", state); end
   endtask

   task automatic test_async_reset();
      logic [NSAT-1:0][5:0] exp_ca;
      exp_ca = {6'd3, 6'd2, 6'd1, 6'd0};
      do_reset();
      wr(8'd3, 3'd1, 32'h55);
      commit = 1; tick(); commit = 0; tick();
      start = 1; tick(); start = 0;
      tick();
      cfg_valid = 1; cfg_sat = 8'd0; cfg_field = 3'd0; cfg_data = 32'hABC; commit = 1;
      tick();
      cfg_valid = 0; commit = 0;
      total++; if (cfg_ready !== 1'b0 || gain[3] !== 16'h55) begin bad++; $display("FAIL areset_setup got ready=%0b gain3=0x%04h want 0/0x0055", cfg_ready, gain[3]); end
      #2 rst_n = 1'b0;
      $display("txn async reset mid-epoch");
      #1;
      total++; if (enable !== 1'b0 || state !== 2'd0 || epoch !== 1'b0) begin bad++; $display("FAIL areset_ctrl got en=%0b state=%0d ep=%0b want 0/0/0", enable, state, epoch); end
      total++; if (gain[3] !== 16'h0 || ca_sel !== exp_ca) begin bad++; $display("FAIL areset_active got gain3=0x%04h ca=%h want 0/%h", gain[3], ca_sel, exp_ca); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%0b want=1", cfg_ready); end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL areset_release_ready got=%0b want=1", cfg_ready); end
      repeat (EP + 2) tick();
      total++; if (freq[0] !== 32'h0) begin bad++; $display("FAIL areset_no_commit got=0x%08h want=0x00000000", freq[0]); end
   endtask

   task automatic test_random();
      logic [NSAT-1:0][31:0] e_freq;
      logic [NSAT-1:0][15:0] e_gain;
      logic [NSAT-1:0][5:0]  e_ca;
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         start     = ($urandom_range(0, 99) < 4);
         stop      = ($urandom_range(0, 99) < 3);
         commit    = ($urandom_range(0, 99) < 6);
         cfg_valid = ($urandom_range(0, 99) < 40);
         cfg_sat   = 8'($urandom_range(0, 4));
         cfg_field = 3'($urandom_range(0, 5));
         cfg_data  = $urandom;
         if (cfg_field == 3'd2 && $urandom_range(0, 3) != 0) cfg_data = 32'($urandom_range(0, 35));
         tick();
         for (int i = 0; i < NSAT; i++) begin
            e_freq[i] = m_act_freq[i]; e_gain[i] = m_act_gain[i]; e_ca[i] = m_act_ca[i];
         end
         total++; if (state !== 2'(m_mode)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d want=%0d", n, state, m_mode); end
         total++; if (enable !== (m_mode != 0)) begin bad++; $display("FAIL rnd_enable cyc=%0d got=%0b want=%0b", n, enable, m_mode != 0); end
         total++; if (epoch !== model_epoch()) begin bad++; $display("FAIL rnd_epoch cyc=%0d got=%0b want=%0b", n, epoch, model_epoch()); end
         total++; if (cfg_ready !== !m_pending) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", n, cfg_ready, !m_pending); end
         total++; if (cfg_err !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%0b want=%0b", n, cfg_err, m_err); end
         total++; if (freq !== e_freq) begin bad++; $display("FAIL rnd_freq cyc=%0d got=%h want=%h", n, freq, e_freq); end
         total++; if (gain !== e_gain) begin bad++; $display("FAIL rnd_gain cyc=%0d got=%h want=%h", n, gain, e_gain); end
         total++; if (ca_sel !== e_ca) begin bad++; $display("FAIL rnd_ca cyc=%0d got=%h want=%h", n, ca_sel, e_ca); end
         total++; if (noise_gain !== m_act_noise) begin bad++; $display("FAIL rnd_noise cyc=%0d got=%h want=%h", n, noise_gain, m_act_noise); end
      end
      start = 0; stop = 0; commit = 0; cfg_valid = 0;
      $display("txn random phase 1500 cycles");
   endtask

   initial begin
      test_reset();
      test_commit_run();
      test_rate();
      test_invalid();
      test_stop();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gps_emulator_ctrl.md
Name: gps_emulator_ctrl

Overview:
Run-time controller for the multi-satellite GPS emulator. It accepts per-satellite configuration writes (Doppler frequency, gain, C/A select, Doppler rate, noise gain) through a valid/ready port into shadow registers. It applies committed shadow values atomically on 1 ms epoch boundaries and ramps each Doppler word by its rate every epoch. It also sequences the emulator enable with start/stop requests. Its outputs drive the emulator's enable, freq, gain, ca_sel and noise_gain inputs directly.

Parameters:
Nsat, 4, number of satellite channels.
EPOCH_CYCLES, 100000, clocks per epoch (1 ms at 100 MHz); must be >= 2.

Ports:
clk  in  1  system clock, all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin emulation
stop  in  1  single-cycle request to end emulation at next epoch boundary
cfg_valid  in  1  configuration write request
cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
cfg_sat  in  8  satellite index, 0..Nsat-1
cfg_field  in  3  0=freq, 1=gain, 2=ca_sel, 3=rate (signed), 4=noise_gain (cfg_sat ignored)
cfg_data  in  32  write data, LSB-aligned; upper bits ignored for narrow fields
commit  in  1  single-cycle request to transfer shadow to active
cfg_err  out  1  one-cycle pulse: the write accepted in the previous cycle was dropped
enable  out  1  emulator enable
freq  out  32 x Nsat  active Doppler phase increment per satellite
gain  out  16 x Nsat  active gain per satellite
ca_sel  out  6 x Nsat  active C/A select (0..35 = SV 1..36)
noise_gain  out  16  active noise gain
epoch  out  1  one-cycle pulse on each epoch terminal count while running
state  out  2  0=IDLE, 1=RUN, 2=STOPPING

Behaviour:
- Reset (async, while rst_n=0):
  - enable=0, epoch=0, cfg_err=0, state=IDLE, epoch counter=0, commit_pending=0.
  - freq, gain, rate and noise_gain are 0 in both shadow and active copies.
  - ca_sel[i]=i in both shadow and active copies.
  - Reset mid-run aborts immediately; no partial commit survives.
- cfg_ready = !commit_pending. The shadow set is locked while a commit waits.
- Accepted write: the shadow field updates on the same edge.
- Dropped writes pulse cfg_err on the next cycle and leave the shadow unchanged. A write is dropped when:
  - cfg_sat >= Nsat with cfg_field != 4;
  - cfg_field > 4;
  - cfg_field = 2 with cfg_data[5:0] > 35.
- Commit:
  - commit sets commit_pending.
  - A write accepted in the same cycle as commit is included in that commit.
  - commit while already pending is ignored.
- IDLE:
  - enable=0 and the counter is held at 0.
  - If commit_pending, active <= shadow on the next edge and pending clears.
  - start: active <= shadow, pending clears, counter <= 0, enable <= 1, state <= RUN. enable is high 1 cycle after the start pulse.
  - stop is ignored in IDLE. If start and stop arrive together, start wins.
- RUN:
  - The counter increments and wraps at EPOCH_CYCLES-1 (terminal count, TC).
  - At TC, epoch pulses for 1 cycle.
  - At TC with commit_pending: active <= shadow and pending clears. No rate step is applied that epoch.
  - At TC without commit_pending: freq[i] <= freq[i] + rate[i] for every i, mod 2^32, with rate two's-complement. Wrap-around is silent.
  - stop: state <= STOPPING. start is ignored.
- STOPPING:
  - Behaves as RUN until the next TC, including commit and rate handling at that TC.
  - At TC: epoch pulses, enable <= 0, counter <= 0, state <= IDLE.
  - start and stop are ignored in STOPPING.
- Active outputs change only on the edges listed above and never mid-epoch while running.

Test Plan:
- Reset sequence (EPOCH_CYCLES=10): reset then release -> enable=0, ca_sel={3,2,1,0}, cfg_ready=1, state=0. Write freq[1]=0x1000, commit in IDLE -> freq[1]=0x1000 two cycles after commit.
- Start, then write gain[0]=0x4000 and commit at counter=3 -> cfg_ready low for 6 cycles. gain[0] changes to 0x4000 exactly on the epoch pulse edge; a write attempted meanwhile is stalled, not lost.
- rate[2]=-5 with freq[2]=3, running, no commits -> freq[2] = 0xFFFFFFFE after 1 epoch and 0xFFFFFFF9 after 2 (wrap-around).
- Invalid writes: cfg_sat=4, cfg_field=5, ca_sel data=36 -> cfg_err pulses once each, shadow unchanged, no handshake stall.
- stop at counter=2 -> enable stays 1 until the TC, epoch pulse seen, enable=0 next cycle, state IDLE. start during STOPPING has no effect.
- Async reset asserted mid-epoch with commit_pending=1 -> outputs return to reset values immediately, pending cleared, cfg_ready=1 after release.
